// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: power-on debounce, menu-armed level selection,
// hurricane hand-back and a fixed-length self-clean countdown.
module hood_mode_ctrl (
  input  logic       clk_1hz,
  input  logic       rst,
  input  logic       power_sw,
  input  logic       menu_sw,
  input  logic       lvl1_sw,
  input  logic       lvl2_sw,
  input  logic       lvl3_sw,
  input  logic       clean_sw,
  input  logic       hurricane_en,
  input  logic       return_sel,
  output logic [2:0] mode_state,
  output logic       menu_armed,
  output logic [7:0] clean_remain,
  output logic       clean_done
);

  typedef enum logic [2:0] {
    ST_STBY  = 3'b000,
    ST_L1    = 3'b001,
    ST_L2    = 3'b010,
    ST_L3    = 3'b011,
    ST_CLEAN = 3'b100,
    ST_OFF   = 3'b111
  } mode_t;

  localparam logic [7:0] CLEAN_SECS = 8'd180;

  mode_t      state;
  logic [1:0] pwr_cnt;
  logic       hur_seen;

  // Switch order: {power, menu, lvl1, lvl2, lvl3, clean}
  logic [5:0] sw_now;
  logic [5:0] sw_prev;
  logic [5:0] sw_edge;

  assign sw_now  = {power_sw, menu_sw, lvl1_sw, lvl2_sw, lvl3_sw, clean_sw};
  assign sw_edge = sw_now & ~sw_prev;

  logic pwr_rise, menu_edge, lvl1_edge, lvl2_edge, lvl3_edge, clean_edge;
  assign pwr_rise   = sw_edge[5];
  assign menu_edge  = sw_edge[4];
  assign lvl1_edge  = sw_edge[3];
  assign lvl2_edge  = sw_edge[2];
  assign lvl3_edge  = sw_edge[1];
  assign clean_edge = sw_edge[0];

  assign mode_state = state;

  always_ff @(posedge clk_1hz or negedge rst) begin
    if (!rst) begin
      state        <= ST_OFF;
      menu_armed   <= 1'b0;
      clean_remain <= 8'd0;
      clean_done   <= 1'b0;
      pwr_cnt      <= 2'd0;
      hur_seen     <= 1'b0;
      sw_prev      <= 6'd0;
    end else begin
      sw_prev    <= sw_now;
      clean_done <= 1'b0;
      if (state == ST_OFF) begin
        // A rising power edge always restarts the run at one sample.
        if (power_sw) begin
          if (pwr_cnt == 2'd2) begin
            state      <= ST_STBY;
            pwr_cnt    <= 2'd0;
            menu_armed <= 1'b0;
          end else begin
            pwr_cnt <= pwr_rise ? 2'd1 : pwr_cnt + 2'd1;
          end
        end else begin
          pwr_cnt <= 2'd0;
        end
      end else if (!power_sw) begin
        state        <= ST_OFF;
        menu_armed   <= 1'b0;
        clean_remain <= 8'd0;
        pwr_cnt      <= 2'd0;
        hur_seen     <= 1'b0;
      end else begin
        case (state)
          ST_STBY: begin
            if (menu_armed) begin
              if (clean_edge) begin
                state        <= ST_CLEAN;
                clean_remain <= CLEAN_SECS;
                menu_armed   <= 1'b0;
              end else if (lvl3_edge && hurricane_en) begin
                state      <= ST_L3;
                hur_seen   <= 1'b0;
                menu_armed <= 1'b0;
              end else if (lvl2_edge) begin
                state      <= ST_L2;
                menu_armed <= 1'b0;
              end else if (lvl1_edge) begin
                state      <= ST_L1;
                menu_armed <= 1'b0;
              end
            end else if (menu_edge) begin
              menu_armed <= 1'b1;
            end
          end
          ST_L1: begin
            if (menu_edge)      state <= ST_STBY;
            else if (lvl2_edge) state <= ST_L2;
          end
          ST_L2: begin
            if (menu_edge)      state <= ST_STBY;
            else if (lvl1_edge) state <= ST_L1;
          end
          ST_L3: begin
            // Leave only once hurricane has been seen running and then stops.
            if (hurricane_en) begin
              hur_seen <= 1'b1;
            end else if (hur_seen) begin
              hur_seen <= 1'b0;
              state    <= return_sel ? ST_L2 : ST_STBY;
            end
          end
          ST_CLEAN: begin
            if (clean_remain <= 8'd1) begin
              clean_remain <= 8'd0;
              clean_done   <= 1'b1;
              state        <= ST_STBY;
            end else begin
              clean_remain <= clean_remain - 8'd1;
            end
          end
          default: begin
            state        <= ST_OFF;
            menu_armed   <= 1'b0;
            clean_remain <= 8'd0;
            pwr_cnt      <= 2'd0;
            hur_seen     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/hood_mode_ctrl.md
HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 The block SHALL have the port `clk_1hz`: input, 1 bit, the 1 Hz system tick; all state updates on its rising edge.
REQ-002 The block SHALL have the port `rst`: input, 1 bit, asynchronous, active-low reset.
REQ-003 The block SHALL have the port `power_sw`: input, 1 bit, level power switch, sampled each clk_1hz edge.
REQ-004 The block SHALL have the port `menu_sw`: input, 1 bit, level menu switch; only its sampled rising edge acts.
REQ-005 The block SHALL have the ports `lvl1_sw`, `lvl2_sw`, `lvl3_sw` and `clean_sw`: inputs, 1 bit each, level request switches; only their sampled rising edges act.
REQ-006 The block SHALL have the port `hurricane_en`: input, 1 bit, from the downstream fan/timer stage; 1 means hurricane is still available or running.
REQ-007 The block SHALL have the port `return_sel`: input, 1 bit, from the downstream stage; 0 means return to standby after hurricane, 1 means return to level 2.
REQ-008 The block SHALL have the port `mode_state`: output, 3 bits; encoding 000 standby, 001 L1, 010 L2, 011 L3 (hurricane), 100 clean, 111 off.
REQ-009 The block SHALL have the port `menu_armed`: output, 1 bit; 1 means a menu edge is pending in standby.
REQ-010 The block SHALL have the port `clean_remain`: output, 8 bits, unsigned; seconds left in clean mode, 0 otherwise.
REQ-011 The block SHALL have the port `clean_done`: output, 1 bit; a one-cycle pulse when clean mode completes normally.

Function
REQ-012 The block SHALL keep one-cycle-delayed copies of all six switches and define edge as (current=1 AND previous=0).
REQ-013 The block SHALL treat OFF as follows: it counts consecutive cycles with power_sw=1; on the 3rd consecutive 1 it enters STANDBY with menu_armed=0; any 0 clears the counter.
REQ-014 The block SHALL, in any state other than OFF, treat power_sw=0 as a transition to OFF on that edge: it clears the menu_armed flag, the clean counter, the power counter and the hurricane-seen flag.
REQ-015 The block SHALL, in STANDBY, set menu_armed on a menu_sw edge.
REQ-016 The block SHALL, in STANDBY with menu_armed=1, accept a request edge using priority clean > lvl3 > lvl2 > lvl1, enter the target mode, and clear menu_armed.
REQ-017 The block SHALL ignore an lvl3 edge when hurricane_en=0: the state is unchanged and menu_armed stays 1; a simultaneous lower-priority edge is then taken.
REQ-018 The block SHALL, in L1, go to L2 on an lvl2_sw edge, and in L2 go to L1 on an lvl1_sw edge.
REQ-019 The block SHALL, in L1 and L2, go to STANDBY on a menu_sw edge (menu has priority over a level edge in the same cycle), and ignore lvl3 and clean edges.
REQ-020 The block SHALL, in L3, ignore all switch edges except power-off.
REQ-021 The block SHALL, in L3, set an internal hurricane-seen flag while hurricane_en=1; when the flag is 1 and hurricane_en=0, it moves to STANDBY if return_sel=0 or to L2 if return_sel=1, and clears the flag.
REQ-022 The block SHALL, on entering CLEAN, load clean_remain=180.
REQ-023 The block SHALL, in CLEAN, decrement clean_remain by 1 per cycle.
REQ-024 The block SHALL, when clean_remain=1 in CLEAN, set clean_remain to 0, move to STANDBY, and assert clean_done for that one cycle.
REQ-025 The block SHALL, in CLEAN, ignore menu and level edges.
REQ-026 The block SHALL drive clean_remain=0 in every non-CLEAN state.
REQ-027 The block SHALL produce no underflow: clean_remain never wraps below 0.
REQ-028 The block SHALL make all outputs registered, and changes SHALL appear on the same edge as the state transition.

Reset
REQ-029 The block SHALL, while rst=0, immediately force mode_state=111 (OFF), menu_armed=0, clean_remain=0, clean_done=0, power counter=0, hurricane-seen flag=0 and all edge registers=0.
REQ-030 The block SHALL, on rst release, start at OFF and require 3 consecutive power_sw=1 samples to reach STANDBY.
REQ-031 The block SHALL, when rst asserts mid-clean or mid-hurricane, abort the mode with no clean_done pulse.

Verification
REQ-032 The bench SHALL cover power-on: power_sw=1 for cycles 1–3 from OFF -> mode_state=000 after the 3rd edge; a pattern 1,1,0,1 -> stays 111.
REQ-033 The bench SHALL cover level selection: in STANDBY, menu edge, then lvl2 edge -> 010; then lvl1 edge -> 001; then menu edge -> 000.
REQ-034 The bench SHALL cover hurricane return: with hurricane_en=1, menu then lvl3 -> 011; drop hurricane_en with return_sel=1 -> 010 next edge; repeat with hurricane_en=0 and an lvl3 edge -> stays 000, menu_armed=1.
REQ-035 The bench SHALL cover clean: menu then clean edge -> 100, clean_remain=180; after 179 more edges clean_remain=1; the next edge -> 000, clean_remain=0, clean_done=1 for exactly one cycle.
REQ-036 The bench SHALL cover simultaneous edges: menu armed, with clean, lvl3 and lvl2 rising together and hurricane_en=1 -> 100.
REQ-037 The bench SHALL cover aborts: power_sw=0 during CLEAN at clean_remain=90 -> 111 with clean_remain=0 and no clean_done; rst=0 during L3 -> 111 asynchronously.
